// File: rtl/mux_rr_stream.sv
// N-input round-robin streaming multiplexer with a registered valid/ready output stage.
// Define MUX_FORCE_SEL_EN to add the force_en/force_sel override ports.
module mux_rr_stream #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic [N*W-1:0]    in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel
`ifdef MUX_FORCE_SEL_EN
    ,
    input  logic              force_en,
    input  logic [SELW-1:0]   force_sel
`endif
);

    logic [SELW-1:0] ptr;
    logic            load;
    logic            forcing;
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic            grant_found;
    logic [SELW-1:0] grant_idx;
    logic            transfer;
    logic [W-1:0]    chan_data [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*W +: W];
    end

    assign load = !out_valid || out_ready;

    // Search ptr, ptr+1, ... wrapping at N; the first hit is the nearest valid channel.
    always_comb begin
        int              cand;
        logic [SELW-1:0] cand_sel;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_sel = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_sel = SELW'(cand);
            if (!rr_found && in_valid[cand_sel]) begin
                rr_found = 1'b1;
                rr_idx   = cand_sel;
            end
        end
    end

`ifdef MUX_FORCE_SEL_EN
    assign forcing = force_en;

    always_comb begin
        if (force_en) begin
            grant_found = (32'(force_sel) < 32'(N)) && in_valid[force_sel];
            grant_idx   = force_sel;
        end else begin
            grant_found = rr_found;
            grant_idx   = rr_idx;
        end
    end
`else
    assign forcing     = 1'b0;
    assign grant_found = rr_found;
    assign grant_idx   = rr_idx;
`endif

    // Ready is held low during reset so no producer believes a word was taken.
    assign transfer = rst_n && load && grant_found;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = transfer && (grant_idx == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= chan_data[grant_idx];
                out_sel   <= grant_idx;
                if (!forcing) begin
                    ptr <= (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: an N=4 and an N=3 instance checked against a round-robin reference model.
// Directed scenarios first, then randomized traffic with an asynchronous reset in the middle.
module tb_mux_rr_stream;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]     in_valid4, in_ready4;
    logic [4*W-1:0] in_data4;
    logic           out_valid4, out_ready4;
    logic [W-1:0]   out_data4;
    logic [1:0]     out_sel4;

    logic [2:0]     in_valid3, in_ready3;
    logic [3*W-1:0] in_data3;
    logic           out_valid3, out_ready3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_sel3;

`ifdef MUX_FORCE_SEL_EN
    logic           force_en4, force_en3;
    logic [1:0]     force_sel4, force_sel3;
`endif

    mux_rr_stream #(.N(4), .W(W)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid4),
        .in_ready (in_ready4),
        .in_data  (in_data4),
        .out_valid(out_valid4),
        .out_ready(out_ready4),
        .out_data (out_data4),
        .out_sel  (out_sel4)
`ifdef MUX_FORCE_SEL_EN
        ,
        .force_en (force_en4),
        .force_sel(force_sel4)
`endif
    );

    mux_rr_stream #(.N(3), .W(W)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid3),
        .in_ready (in_ready3),
        .in_data  (in_data3),
        .out_valid(out_valid3),
        .out_ready(out_ready3),
        .out_data (out_data3),
        .out_sel  (out_sel3)
`ifdef MUX_FORCE_SEL_EN
        ,
        .force_en (force_en3),
        .force_sel(force_sel3)
`endif
    );

    int           n_ch [2] = '{4, 3};
    bit           s_valid [2][4];
    logic [W-1:0] s_data [2][4];
    bit           s_ready [2];
    bit           s_force [2];
    int           s_fsel [2];

    int           m_ptr [2];
    bit           m_valid [2];
    logic [W-1:0] m_data [2];
    int           m_sel [2];
    int           last_grant [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 4; i++) begin
            in_valid4[i]       = s_valid[0][i];
            in_data4[i*W +: W] = s_data[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            in_valid3[i]       = s_valid[1][i];
            in_data3[i*W +: W] = s_data[1][i];
        end
        out_ready4 = s_ready[0];
        out_ready3 = s_ready[1];
`ifdef MUX_FORCE_SEL_EN
        force_en4  = s_force[0];
        force_sel4 = 2'(s_fsel[0]);
        force_en3  = s_force[1];
        force_sel3 = 2'(s_fsel[1]);
`endif
    endtask

    // Expected granted channel for the current cycle, or -1 when nothing may be accepted.
    function automatic int expGrant(input int d);
        int n;
        int c;
        n = n_ch[d];
        if (!rst_n) return -1;
        if (m_valid[d] && !s_ready[d]) return -1;
        if (s_force[d]) begin
            if (s_fsel[d] >= n) return -1;
            return s_valid[d][s_fsel[d]] ? s_fsel[d] : -1;
        end
        for (int k = 0; k < n; k++) begin
            c = (m_ptr[d] + k) % n;
            if (s_valid[d][c]) return c;
        end
        return -1;
    endfunction

    task automatic modelEdge(input int d, input int g);
        if (!rst_n) return;
        if (g >= 0) begin
            m_valid[d] = 1'b1;
            m_data[d]  = s_data[d][g];
            m_sel[d]   = g;
            if (!s_force[d]) m_ptr[d] = (g + 1) % n_ch[d];
        end else if (s_ready[d]) begin
            m_valid[d] = 1'b0;
        end
    endtask

    task automatic checkReady(input int d, input int g);
        logic [31:0] obs;
        logic [31:0] exp_ready;
        obs       = (d == 0) ? 32'(in_ready4) : 32'(in_ready3);
        exp_ready = (g >= 0) ? (32'(1) << g) : 32'(0);
        check($sformatf("N%0d in_ready", n_ch[d]), obs, exp_ready);
    endtask

    task automatic checkOutput(input int d);
        if (d == 0) begin
            check("N4 out_valid", 32'(out_valid4), 32'(m_valid[0]));
            check("N4 out_data",  32'(out_data4),  32'(m_data[0]));
            check("N4 out_sel",   32'(out_sel4),   32'(m_sel[0]));
        end else begin
            check("N3 out_valid", 32'(out_valid3), 32'(m_valid[1]));
            check("N3 out_data",  32'(out_data3),  32'(m_data[1]));
            check("N3 out_sel",   32'(out_sel3),   32'(m_sel[1]));
        end
    endtask

    task automatic cycle();
        int g [2];
        applyStimulus();
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d] = expGrant(d);
            checkReady(d, g[d]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            modelEdge(d, g[d]);
            checkOutput(d);
            last_grant[d] = g[d];
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_valid[d]    = 1'b0;
            m_data[d]     = '0;
            m_sel[d]      = 0;
            m_ptr[d]      = 0;
            last_grant[d] = -1;
        end
        applyStimulus();
        #1;
        for (int d = 0; d < 2; d++) begin
            checkReady(d, -1);
            checkOutput(d);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkReady(d, -1);
            checkOutput(d);
        end
        rst_n = 1'b1;
    endtask

    task automatic setAllValid();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                s_valid[d][i] = (i < n_ch[d]);
                s_data[d][i]  = 8'hA0 + W'(i);
            end
            s_ready[d] = 1'b1;
            s_force[d] = 1'b0;
            s_fsel[d]  = 0;
        end
    endtask

    // Pending words stay put until accepted; a pending channel occasionally withdraws.
    task automatic randomStimulus();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < n_ch[d]; i++) begin
                if (s_valid[d][i] && last_grant[d] != i) begin
                    if ($urandom_range(0, 7) == 0) s_valid[d][i] = 1'b0;
                end else begin
                    s_valid[d][i] = ($urandom_range(0, 2) != 0);
                    s_data[d][i]  = W'($urandom);
                end
            end
            s_ready[d] = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        setAllValid();
        doReset();

        // All channels valid: grants rotate and one word per cycle leaves.
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rotate N4 sel",  32'(out_sel4),  32'(k % 4));
            check("rotate N4 data", 32'(out_data4), 32'(8'hA0 + k % 4));
            check("rotate N3 sel",  32'(out_sel3),  32'(k % 3));
            check("rotate N3 data", 32'(out_data3), 32'(8'hA0 + k % 3));
        end

        // Consumer stalls: the held word stays and nothing is accepted.
        s_ready[0] = 1'b0;
        s_ready[1] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            cycle();
            check("stall N4 sel",      32'(out_sel4),  32'(0));
            check("stall N4 data",     32'(out_data4), 32'(8'hA0));
            check("stall N4 in_ready", 32'(in_ready4), 32'(0));
            check("stall N3 sel",      32'(out_sel3),  32'(1));
        end
        s_ready[0] = 1'b1;
        s_ready[1] = 1'b1;
        cycle();
        check("resume N4 sel",  32'(out_sel4),  32'(1));
        check("resume N4 data", 32'(out_data4), 32'(8'hA1));
        check("resume N3 sel",  32'(out_sel3),  32'(2));

        // Sparse traffic on the N=4 instance, idle cycles between.
        doReset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) s_valid[d][i] = 1'b0;
        end
        s_valid[0][2] = 1'b1;
        cycle();
        check("sparse first sel", 32'(out_sel4), 32'(2));
        s_valid[0][2] = 1'b0;
        cycle();
        cycle();
        check("sparse idle valid", 32'(out_valid4), 32'(0));
        s_valid[0][1] = 1'b1;
        s_valid[0][2] = 1'b1;
        cycle();
        check("sparse wrap sel", 32'(out_sel4), 32'(1));
        s_valid[0][1] = 1'b0;
        cycle();
        check("sparse next sel", 32'(out_sel4), 32'(2));

        // Random traffic with an asynchronous reset partway through.
        for (int c = 0; c < 400; c++) begin
            randomStimulus();
            if (c == 200) doReset();
            cycle();
        end

`ifdef MUX_FORCE_SEL_EN
        setAllValid();
        doReset();
        for (int d = 0; d < 2; d++) begin
            s_force[d] = 1'b1;
            s_fsel[d]  = 2;
        end
        for (int r = 0; r < 3; r++) begin
            cycle();
            check("force N4 sel", 32'(out_sel4), 32'(2));
            check("force N3 sel", 32'(out_sel3), 32'(2));
        end
        s_fsel[0] = 3;
        s_fsel[1] = 3;
        cycle();
        check("force N4 sel3",      32'(out_sel4),   32'(3));
        check("force N3 out_range", 32'(out_valid3), 32'(0));
        cycle();
        check("force N3 no grant",  32'(in_ready3),  32'(0));
        s_force[0] = 1'b0;
        s_force[1] = 1'b0;
        cycle();
        check("unforce N4 sel", 32'(out_sel4), 32'(0));
        check("unforce N3 sel", 32'(out_sel3), 32'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
